// File: rtl/mem_ctrl_top.sv
// mem_ctrl_top: sequences STORE/FETCH/CLEAR commands onto a 64x32 single-port RAM,
// keeping FIFO write/read pointers and a word count internally.
// Ports:
//   mc_clk, mc_reset          clock, async active-high reset
//   mc_data_in                word to store
//   mc_data_contition         command (000 NOP, 001 STORE, 010 FETCH, 100 CLEAR)
//   mc_data_length            FETCH size (0 = one operand, 1 = two operands)
//   mc_data_out_opa/opb       fetched operands
//   mc_done                   one-cycle completion pulse
//   mc_data_done              operands valid (level)
//   mc_we, mc_address_mem,
//   mem_data_in               RAM write enable / address / write data
//   mem_data_out              RAM read data
// single_port_ram: 64x32 RAM, synchronous write, registered read (read-old-data).

module mem_ctrl_top (
    input  logic        mc_clk,
    input  logic        mc_reset,
    input  logic [31:0] mc_data_in,
    input  logic [2:0]  mc_data_contition,
    input  logic        mc_data_length,
    output logic [31:0] mc_data_out_opa,
    output logic [31:0] mc_data_out_opb,
    output logic        mc_done,
    output logic        mc_data_done,
    output logic        mc_we,
    output logic [5:0]  mc_address_mem,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 7;
    localparam int unsigned DEPTH = 64;

    localparam logic [2:0] CMD_STORE = 3'b001;
    localparam logic [2:0] CMD_FETCH = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RDA, S_CPA, S_RDB, S_CPB, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           len_q, len_d;
    logic [DW-1:0]  opa_q, opa_d;
    logic [DW-1:0]  opb_q, opb_d;
    logic           done_q, done_d;
    logic           data_done_q, data_done_d;
    logic           we_q, we_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]  need_c;

    assign need_c = mc_data_length ? CW'(2) : CW'(1);

    // State and datapath registers
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            len_q       <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            done_q      <= 1'b0;
            data_done_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            done_q      <= done_d;
            data_done_q <= data_done_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and output logic; pointers/count only move when a command completes
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        len_d       = len_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        done_d      = 1'b0;
        data_done_d = data_done_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                case (mc_data_contition)
                    CMD_STORE: begin
                        data_done_d = 1'b0;
                        if (count_q == CW'(DEPTH)) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = wr_ptr_q;
                            wdata_d = mc_data_in;
                            state_d = S_WR;
                        end
                    end
                    CMD_FETCH: begin
                        data_done_d = 1'b0;
                        len_d       = mc_data_length;
                        if (count_q < need_c) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            addr_d  = rd_ptr_q;
                            state_d = S_RDA;
                        end
                    end
                    CMD_CLEAR: begin
                        data_done_d = 1'b0;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        count_d     = '0;
                        done_d      = 1'b1;
                        state_d     = S_DONE;
                    end
                    default: ;
                endcase
            end
            S_WR: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_RDA: state_d = S_CPA;
            S_CPA: begin
                opa_d = mem_data_out;
                if (!len_q) begin
                    opb_d       = '0;
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    count_d     = count_q - CW'(1);
                    done_d      = 1'b1;
                    data_done_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    addr_d  = rd_ptr_q + AW'(1);
                    state_d = S_RDB;
                end
            end
            S_RDB: state_d = S_CPB;
            S_CPB: begin
                opb_d       = mem_data_out;
                rd_ptr_d    = rd_ptr_q + AW'(2);
                count_d     = count_q - CW'(2);
                done_d      = 1'b1;
                data_done_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mc_data_out_opa = opa_q;
    assign mc_data_out_opb = opb_q;
    assign mc_done         = done_q;
    assign mc_data_done    = data_done_q;
    assign mc_we           = we_q;
    assign mc_address_mem  = addr_q;
    assign mem_data_in     = wdata_q;

endmodule

module single_port_ram (
    input  logic        mem_clk,
    input  logic        mem_we,
    input  logic [5:0]  mem_address,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_data_out
);

    localparam int unsigned DEPTH = 64;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read captures the pre-write contents, so a same-address write returns old data
    always_ff @(posedge mem_clk) begin
        if (mem_we) mem_q[mem_address] <= mem_data_in;
        rdata_q <= mem_q[mem_address];
    end

    assign mem_data_out = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_top.sv
module tb_mem_ctrl_top;

    localparam logic [2:0] C_NOP   = 3'b000;
    localparam logic [2:0] C_STORE = 3'b001;
    localparam logic [2:0] C_FETCH = 3'b010;
    localparam logic [2:0] C_CLEAR = 3'b100;

    logic        clk;
    logic        rst;
    logic [31:0] din_i;
    logic [2:0]  cmd_i;
    logic        len_i;
    logic [31:0] opa, opb;
    logic        done, data_done;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    mem_ctrl_top dut (
        .mc_clk            (clk),
        .mc_reset          (rst),
        .mc_data_in        (din_i),
        .mc_data_contition (cmd_i),
        .mc_data_length    (len_i),
        .mc_data_out_opa   (opa),
        .mc_data_out_opb   (opb),
        .mc_done           (done),
        .mc_data_done      (data_done),
        .mc_we             (we),
        .mc_address_mem    (addr),
        .mem_data_in       (wdata),
        .mem_data_out      (rdata)
    );

    single_port_ram u_ram (
        .mem_clk      (clk),
        .mem_we       (we),
        .mem_address  (addr),
        .mem_data_in  (wdata),
        .mem_data_out (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: FIFO contents plus the expected output values for the current cycle
    logic [31:0] q[$];
    int          model_wr;
    logic        exp_done, exp_dd, exp_we;
    logic [31:0] exp_opa, exp_opb, exp_wdata;
    logic [5:0]  exp_addr;
    bit          chk_en;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mc_done", 32'(done), 32'(exp_done));
            chk("mc_data_done", 32'(data_done), 32'(exp_dd));
            chk("opa", opa, exp_opa);
            chk("opb", opb, exp_opb);
            chk("mc_we", 32'(we), 32'(exp_we));
            if (exp_we) begin
                chk("wr_addr", 32'(addr), 32'(exp_addr));
                chk("wr_data", wdata, exp_wdata);
            end
        end
    end

    task automatic model_reset();
        q.delete();
        model_wr  = 0;
        exp_done  = 1'b0;
        exp_dd    = 1'b0;
        exp_we    = 1'b0;
        exp_opa   = '0;
        exp_opb   = '0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    // Issue one command and walk the expected timeline edge by edge after acceptance
    task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] d, input logic len);
        int          lat;
        bit          ok;
        bit          is_fetch;
        int          need;
        logic [31:0] a, b;
        ok = 0; lat = 0; a = '0; b = '0;
        is_fetch = (cmd == C_FETCH);
        need = len ? 2 : 1;
        if (cmd == C_STORE && q.size() < 64) begin
            ok = 1; lat = 1;
        end
        if (is_fetch && q.size() >= need) begin
            ok = 1; lat = len ? 4 : 2;
            a = q.pop_front();
            if (len) b = q.pop_front();
        end
        @(negedge clk);
        cmd_i = cmd; din_i = d; len_i = len;
        @(posedge clk); #1;
        cmd_i = C_NOP;
        for (int k = 0; k <= lat + 1; k++) begin
            exp_done = (k == lat);
            exp_we   = (cmd == C_STORE) && ok && (k == 0);
            if (k == 0) begin
                exp_dd = 1'b0;
                if (exp_we) begin
                    exp_addr  = 6'(model_wr);
                    exp_wdata = d;
                end
            end
            if (is_fetch && ok && k == 2) begin
                exp_opa = a;
                if (!len) exp_opb = '0;
            end
            if (is_fetch && ok && k == lat) begin
                exp_opb = len ? b : 32'h0;
                exp_dd  = 1'b1;
            end
            if (k < lat + 1) begin
                @(posedge clk); #1;
            end
        end
        if (cmd == C_STORE && ok) begin
            q.push_back(d);
            model_wr = (model_wr + 1) % 64;
        end
        if (cmd == C_CLEAR) begin
            q.delete();
            model_wr = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din_i = '0; cmd_i = C_NOP; len_i = 1'b0; chk_en = 0;
        model_reset();
        #50 rst = 1'b0;
        #1;
        chk("rst_opa", opa, 32'h0);
        chk("rst_opb", opb, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_data_done", 32'(data_done), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk_en = 1;
        repeat (3) @(posedge clk);
        // Unused command codes act as NOP
        @(negedge clk); cmd_i = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk); cmd_i = 3'b011;
        repeat (2) @(posedge clk);
        #1 cmd_i = C_NOP;

        // Two stores then a two-operand fetch
        do_cmd(C_STORE, 32'hDEADBEEF, 1'b0);
        do_cmd(C_STORE, 32'h12345678, 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b1);
        chk("pair_opa", opa, 32'hDEADBEEF);
        chk("pair_opb", opb, 32'h12345678);
        chk("pair_dd", 32'(data_done), 32'h1);

        // Single fetch, then a rejected fetch on empty
        do_cmd(C_STORE, 32'hA5A5A5A5, 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("single_opa", opa, 32'hA5A5A5A5);
        chk("single_opb", opb, 32'h0);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("empty_opa", opa, 32'hA5A5A5A5);
        chk("empty_dd", 32'(data_done), 32'h0);

        // Fill to 64, overflow store ignored, drain as pairs
        for (int i = 0; i < 64; i++) do_cmd(C_STORE, 32'(i), 1'b0);
        do_cmd(C_STORE, 32'hFFFFFFFF, 1'b0);
        for (int i = 0; i < 32; i++) do_cmd(C_FETCH, 32'h0, 1'b1);
        chk("full_last_opa", opa, 32'd62);
        chk("full_last_opb", opb, 32'd63);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("drained_dd", 32'(data_done), 32'h0);

        // Pointer wrap across address 63 -> 0
        for (int i = 0; i < 60; i++) do_cmd(C_STORE, 32'h5000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 30; i++) do_cmd(C_FETCH, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) do_cmd(C_STORE, 32'h1000_0000 + 32'(i), 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b1);
        chk("wrap_opa", opa, 32'h1000_0000);
        chk("wrap_opb", opb, 32'h1000_0001);
        for (int i = 0; i < 3; i++) do_cmd(C_FETCH, 32'h0, 1'b1);
        chk("wrap_last_opb", opb, 32'h1000_0007);

        // Clear after five stores; next fetch is rejected
        for (int i = 0; i < 5; i++) do_cmd(C_STORE, 32'hC0DE_0000 + 32'(i), 1'b0);
        do_cmd(C_CLEAR, 32'h0, 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("clear_dd", 32'(data_done), 32'h0);
        do_cmd(C_STORE, 32'h0BAD_F00D, 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("clear_restart_opa", opa, 32'h0BAD_F00D);

        // Reset while the second read is in flight
        do_cmd(C_STORE, 32'h7777_0001, 1'b0);
        do_cmd(C_STORE, 32'h7777_0002, 1'b0);
        chk_en = 0;
        @(negedge clk); cmd_i = C_FETCH; len_i = 1'b1;
        @(posedge clk); #1 cmd_i = C_NOP;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_opa", opa, 32'h0);
        chk("abort_opb", opb, 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_dd", 32'(data_done), 32'h0);
        chk("abort_addr", 32'(addr), 32'h0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        chk_en = 1;
        do_cmd(C_FETCH, 32'h0, 1'b0);
        do_cmd(C_STORE, 32'h2468_ACE0, 1'b0);
        do_cmd(C_FETCH, 32'h0, 1'b0);
        chk("post_abort_opa", opa, 32'h2468_ACE0);
        repeat (2) @(posedge clk);
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
